iq_issue_ctrl: RTL and testbench
================================

# iq_issue_ctrl

Issue-select controller for the 16-entry collapsing issue queue. Each cycle it picks the oldest ready, valid IQ entry and returns a grant so the IQ removes that entry. It latches the selected payload into a one-deep issue register and hands it to the functional unit (FU) over a valid/ready handshake. It also caps the number of operations outstanding in the FU and sequences flush recovery.

## Interface
- IQ_LEN, 16, number of IQ entries; entry 0 is oldest.
- IDX_BITS, 4, width of the entry index.
- PAYLOAD_W, 64, width of the issue payload.
- MAX_INFLIGHT, 4, maximum number of granted operations not yet completed.
- CNT_BITS, 3, width of the in-flight counter; must hold MAX_INFLIGHT.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FREEZE  in  1  pipeline freeze; blocks new grants only.
- FLUSH  in  1  squash request, single-cycle pulse or level.
- req_vec  in  IQ_LEN  per-entry ready (operands available).
- entry_valid  in  IQ_LEN  per-entry occupied.
- sel_payload  in  PAYLOAD_W  IQ payload muxed by grant_idx, same cycle.
- fu_ready  in  1  FU accepts issue_data this cycle.
- fu_done  in  1  one outstanding operation has completed.
- grant_valid  out  1  an entry is granted this cycle (combinational).
- grant_idx  out  IDX_BITS  index of the granted entry; 0 when grant_valid=0.
- grant_onehot  out  IQ_LEN  one-hot grant vector; all zeros when no grant.
- issue_valid  out  1  issue register holds an operation.
- issue_data  out  PAYLOAD_W  issue register contents.
- inflight_cnt  out  CNT_BITS  count of granted, not-yet-completed operations.
- drain_busy  out  1  controller is in the DRAIN state.
- done_underflow  out  1  sticky error flag.

## Operation
- **States**
  - RUN is the reset state and the only state that grants.
  - DRAIN blocks all grants.
  - RUN→DRAIN when FLUSH=1.
  - DRAIN→RUN when the next value of inflight_cnt is 0 and FLUSH=0.
  - FLUSH=1 while in DRAIN keeps the state in DRAIN.
- **Candidate vector:** cand = req_vec & entry_valid. The selected entry is the lowest set bit of cand (fixed age priority).
- **Grant condition:** grant_valid = state==RUN, and !FLUSH, and !FREEZE, and |cand, and slot_free, and cap_ok.
  - slot_free = !issue_valid || fu_ready.
  - cap_ok = inflight_cnt < MAX_INFLIGHT || fu_done.
- **On a grant edge:**
  - issue_data <= sel_payload.
  - issue_valid <= 1.
- **Without a grant:**
  - issue_valid <= issue_valid && !fu_ready.
  - issue_data holds its value.
- **In-flight counter:** +1 on grant, −1 on fu_done, unchanged when both occur in the same cycle.
- **fu_done underflow:** fu_done while inflight_cnt=0 with no grant:
  - The counter stays at 0.
  - done_underflow <= 1, held until RESET.
- **FLUSH edge:**
  - issue_valid <= 0.
  - If issue_valid && !fu_ready, the held op is discarded and the counter also takes −1 for it.
  - fu_done in the same cycle is still applied. Combined decrements saturate at 0.
  - If issue_valid && fu_ready, the op is accepted by the FU and stays counted.
- **FREEZE:**
  - The issue register still drains via fu_ready.
  - fu_done is still counted.
  - FLUSH has priority over FREEZE.
- **Reset values:**
  - grant outputs = 0.
  - issue_valid = 0.
  - issue_data = 0.
  - inflight_cnt = 0.
  - drain_busy = 0.
  - done_underflow = 0.
  - state = RUN.
- Reset asserted mid-operation discards the issue register and the counter immediately (asynchronously).

## Timing
- The grant is combinational within cycle t from the registered state and inputs.
- At the end of cycle t, the IQ removes the granted entry and collapses.
- issue_valid/issue_data become visible in cycle t+1.
- Select-to-FU latency is 1 cycle.
- Back-to-back issue happens every cycle while fu_ready=1 and cap_ok holds.
- An FU transfer occurs when issue_valid && fu_ready. While fu_ready=0, issue_data is stable.
- req_vec in cycle t+1 already reflects the collapsed queue; the controller keeps no entry indices across cycles.
- drain_busy is registered and equals state==DRAIN. The first grant after DRAIN is in the cycle following the exit edge.

## Test plan
- **Age priority:** req_vec=0x8014, entry_valid=0xFFFF, issue_valid=0.
  - Cycle t: grant_idx=2, grant_onehot=0x0004.
  - Cycle t+1: issue_valid=1 and issue_data=sel_payload sampled at t.
- **Backpressure:** issue_valid=1, fu_ready=0, cand≠0.
  - grant_valid=0 and issue_data is held.
  - Raise fu_ready=1: grant in that same cycle, and the new payload appears the next cycle.
- **In-flight cap:** MAX_INFLIGHT=4, cand=0xFFFF, fu_ready=1, fu_done=0.
  - Exactly 4 grants, then grant_valid=0 with inflight_cnt=4.
  - A fu_done pulse gives a grant in the same cycle, and inflight_cnt stays 4.
- **Flush:** inflight_cnt=3, issue_valid=1, fu_ready=0, FLUSH pulse.
  - Next cycle: inflight_cnt=2, issue_valid=0, drain_busy=1.
  - No grants until 2 fu_done pulses, then drain_busy=0, and the first grant comes one cycle later.
- **Underflow:** fu_done=1 with inflight_cnt=0.
  - inflight_cnt stays 0, done_underflow=1 and stays set until RESET.
- **Reset mid-operation:** RESET asserted with inflight_cnt=2 and issue_valid=1.
  - All outputs go to 0 without waiting for a clock edge; state is RUN after release.

Source files
------------

// File: rtl/iq_issue_ctrl_if.sv
// iq_issue_ctrl_if
// Groups the issue-select controller's IQ-side and FU-side signals.
//   IQ side : req_vec, entry_valid, sel_payload in; grant_valid, grant_idx,
//             grant_onehot out (combinational, same cycle as the request).
//   FU side : issue_valid/issue_data out with fu_ready back; fu_done reports
//             completion of an outstanding operation.
//   Control : FREEZE, FLUSH in; inflight_cnt, drain_busy, done_underflow out.
// The slave modport is the controller; master is whatever surrounds it.
interface iq_issue_ctrl_if #(
  parameter int IQ_LEN    = 16,
  parameter int IDX_BITS  = 4,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_BITS  = 3
);
  logic                 FREEZE;
  logic                 FLUSH;
  logic [IQ_LEN-1:0]    req_vec;
  logic [IQ_LEN-1:0]    entry_valid;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic                 fu_ready;
  logic                 fu_done;
  logic                 grant_valid;
  logic [IDX_BITS-1:0]  grant_idx;
  logic [IQ_LEN-1:0]    grant_onehot;
  logic                 issue_valid;
  logic [PAYLOAD_W-1:0] issue_data;
  logic [CNT_BITS-1:0]  inflight_cnt;
  logic                 drain_busy;
  logic                 done_underflow;

  modport slave (
    input  FREEZE, FLUSH, req_vec, entry_valid, sel_payload, fu_ready, fu_done,
    output grant_valid, grant_idx, grant_onehot, issue_valid, issue_data,
           inflight_cnt, drain_busy, done_underflow
  );

  modport master (
    output FREEZE, FLUSH, req_vec, entry_valid, sel_payload, fu_ready, fu_done,
    input  grant_valid, grant_idx, grant_onehot, issue_valid, issue_data,
           inflight_cnt, drain_busy, done_underflow
  );
endinterface

// File: rtl/iq_issue_ctrl.sv
// iq_issue_ctrl
// Picks the oldest ready, valid entry of the 16-entry collapsing issue queue,
// latches its payload into a one-deep issue register for the FU, caps the
// number of operations outstanding in the FU and sequences flush recovery.
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RESET - asynchronous active-high reset
//   bus   - iq_issue_ctrl_if slave modport (IQ select, FU handshake, status)
module iq_issue_ctrl #(
  parameter int IQ_LEN       = 16,
  parameter int IDX_BITS     = 4,
  parameter int PAYLOAD_W    = 64,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_BITS     = 3
) (
  input  logic CLK,
  input  logic RESET,
  iq_issue_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_INFLIGHT);

  state_t               state_q, state_d;
  logic                 issue_valid_q;
  logic [PAYLOAD_W-1:0] issue_data_q;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 underflow_q, underflow_set;

  logic [IQ_LEN-1:0]    cand;
  logic [IQ_LEN-1:0]    onehot;
  logic [IDX_BITS-1:0]  idx;
  logic                 grant;
  logic                 flush_drop;
  logic [1:0]           dec;
  logic [CNT_BITS-1:0]  dec_ext;

  // Age-priority select: entry 0 is oldest, so the lowest set candidate bit
  // wins. Scanning downwards leaves the lowest index as the last write.
  always_comb begin
    cand   = bus.req_vec & bus.entry_valid;
    onehot = cand & (~cand + 1'b1);
    idx    = '0;
    for (int i = IQ_LEN - 1; i >= 0; i--) begin
      if (cand[i]) idx = i[IDX_BITS-1:0];
    end
  end

  // A completing op frees its FU credit in the same cycle, so fu_done lets a
  // grant through even at the cap. RESET gates the grant so nothing is
  // offered to the IQ while the controller is held in reset.
  assign grant = !RESET && (state_q == RUN) && !bus.FLUSH && !bus.FREEZE &&
                 (|cand) && (!issue_valid_q || bus.fu_ready) &&
                 ((cnt_q < MAX_CNT) || bus.fu_done);

  // An op still sitting in the issue register at flush time never reaches
  // the FU, so its credit is returned along with any fu_done.
  assign flush_drop = bus.FLUSH && issue_valid_q && !bus.fu_ready;
  assign dec        = {1'b0, bus.fu_done} + {1'b0, flush_drop};
  assign dec_ext    = CNT_BITS'(dec);

  // In-flight counter next value; decrements saturate at zero and a lone
  // fu_done with nothing outstanding raises the sticky underflow flag.
  always_comb begin
    cnt_d         = cnt_q;
    underflow_set = 1'b0;
    if (grant) begin
      if (!bus.fu_done) cnt_d = cnt_q + 1'b1;
    end else begin
      underflow_set = bus.fu_done && (cnt_q == '0);
      cnt_d         = (cnt_q > dec_ext) ? (cnt_q - dec_ext) : '0;
    end
  end

  // Flush recovery: stay in DRAIN until every outstanding op has completed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.FLUSH) state_d = DRAIN;
      DRAIN:   if (!bus.FLUSH && (cnt_d == '0)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= RUN;
      issue_valid_q <= 1'b0;
      issue_data_q  <= '0;
      cnt_q         <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_q || underflow_set;
      if (bus.FLUSH) begin
        issue_valid_q <= 1'b0;
      end else if (grant) begin
        issue_valid_q <= 1'b1;
        issue_data_q  <= bus.sel_payload;
      end else begin
        issue_valid_q <= issue_valid_q && !bus.fu_ready;
      end
    end
  end

  assign bus.grant_valid    = grant;
  assign bus.grant_idx      = grant ? idx : '0;
  assign bus.grant_onehot   = grant ? onehot : '0;
  assign bus.issue_valid    = issue_valid_q;
  assign bus.issue_data     = issue_data_q;
  assign bus.inflight_cnt   = cnt_q;
  assign bus.drain_busy     = (state_q == DRAIN);
  assign bus.done_underflow = underflow_q;

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// tb_iq_issue_ctrl
// Directed bench for iq_issue_ctrl: age priority, backpressure, in-flight
// cap, flush/drain, freeze, underflow and asynchronous reset mid-operation.
module tb_iq_issue_ctrl;

  logic CLK = 1'b0;
  logic RESET;

  int vectors     = 0;
  int miscompares = 0;

  iq_issue_ctrl_if #(.IQ_LEN(16), .IDX_BITS(4), .PAYLOAD_W(64), .CNT_BITS(3)) bus ();

  iq_issue_ctrl #(
    .IQ_LEN(16), .IDX_BITS(4), .PAYLOAD_W(64), .MAX_INFLIGHT(4), .CNT_BITS(3)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive all inputs, then let combinational outputs settle.
  task automatic apply_stimulus(input logic [15:0] req, input logic [15:0] valid,
                                input logic [63:0] payload, input logic ready,
                                input logic done, input logic flush,
                                input logic freeze);
    bus.req_vec     = req;
    bus.entry_valid = valid;
    bus.sel_payload = payload;
    bus.fu_ready    = ready;
    bus.fu_done     = done;
    bus.FLUSH       = flush;
    bus.FREEZE      = freeze;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RESET = 1'b1;
    apply_stimulus(16'h0000, 16'h0000, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    // Reset state, observed before any clock edge
    check_output("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    check_output("rst_issue_data", bus.issue_data, 64'd0);
    check_output("rst_inflight", 64'(bus.inflight_cnt), 64'd0);
    check_output("rst_drain", 64'(bus.drain_busy), 64'd0);
    check_output("rst_underflow", 64'(bus.done_underflow), 64'd0);
    check_output("rst_grant_valid", 64'(bus.grant_valid), 64'd0);
    step();
    RESET = 1'b0;

    // Age priority: oldest candidate of 0x8014 is entry 2
    step();
    apply_stimulus(16'h8014, 16'hFFFF, 64'hA1A1_0000_0000_00A1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("age_grant_valid", 64'(bus.grant_valid), 64'd1);
    check_output("age_grant_idx", 64'(bus.grant_idx), 64'd2);
    check_output("age_onehot", 64'(bus.grant_onehot), 64'h0004);
    step();
    apply_stimulus(16'h0000, 16'hFFFF, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("age_issue_valid", 64'(bus.issue_valid), 64'd1);
    check_output("age_issue_data", bus.issue_data, 64'hA1A1_0000_0000_00A1);
    check_output("age_inflight", 64'(bus.inflight_cnt), 64'd1);
    check_output("idle_grant_idx", 64'(bus.grant_idx), 64'd0);
    step();
    check_output("age_drained", 64'(bus.issue_valid), 64'd0);
    check_output("age_done_cnt", 64'(bus.inflight_cnt), 64'd0);

    // Backpressure: fill the issue register, then stall the FU
    apply_stimulus(16'h0001, 16'hFFFF, 64'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("bp_first_grant", 64'(bus.grant_valid), 64'd1);
    step();
    apply_stimulus(16'h0010, 16'hFFFF, 64'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("bp_stall_grant", 64'(bus.grant_valid), 64'd0);
    check_output("bp_stall_data", bus.issue_data, 64'hB2);
    step();
    check_output("bp_held_valid", 64'(bus.issue_valid), 64'd1);
    check_output("bp_held_data", bus.issue_data, 64'hB2);
    apply_stimulus(16'h0010, 16'hFFFF, 64'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("bp_release_grant", 64'(bus.grant_valid), 64'd1);
    check_output("bp_release_idx", 64'(bus.grant_idx), 64'd4);
    check_output("bp_release_onehot", 64'(bus.grant_onehot), 64'h0010);
    step();
    check_output("bp_new_data", bus.issue_data, 64'hC3);
    check_output("bp_inflight", 64'(bus.inflight_cnt), 64'd2);
    apply_stimulus(16'h0000, 16'hFFFF, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    step();
    check_output("bp_emptied_cnt", 64'(bus.inflight_cnt), 64'd0);

    // In-flight cap: four back-to-back grants, then blocked
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(16'hFFFF, 16'hFFFF, 64'hD0 + 64'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("cap_grant", 64'(bus.grant_valid), 64'd1);
      step();
    end
    apply_stimulus(16'hFFFF, 16'hFFFF, 64'hE5, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("cap_blocked", 64'(bus.grant_valid), 64'd0);
    check_output("cap_cnt_full", 64'(bus.inflight_cnt), 64'd4);
    check_output("cap_last_data", bus.issue_data, 64'hD3);
    apply_stimulus(16'hFFFF, 16'hFFFF, 64'hE5, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("cap_done_grant", 64'(bus.grant_valid), 64'd1);
    step();
    apply_stimulus(16'h0000, 16'hFFFF, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("cap_cnt_kept", 64'(bus.inflight_cnt), 64'd4);
    check_output("cap_done_data", bus.issue_data, 64'hE5);

    // Flush with a stalled op in the issue register and three outstanding
    step();
    check_output("fl_pre_cnt", 64'(bus.inflight_cnt), 64'd3);
    check_output("fl_pre_valid", 64'(bus.issue_valid), 64'd1);
    apply_stimulus(16'hFFFF, 16'hFFFF, 64'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("fl_no_grant", 64'(bus.grant_valid), 64'd0);
    step();
    apply_stimulus(16'hFFFF, 16'hFFFF, 64'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("fl_cnt", 64'(bus.inflight_cnt), 64'd2);
    check_output("fl_valid", 64'(bus.issue_valid), 64'd0);
    check_output("fl_drain", 64'(bus.drain_busy), 64'd1);
    check_output("fl_drain_grant", 64'(bus.grant_valid), 64'd0);
    step();
    check_output("fl_cnt_one", 64'(bus.inflight_cnt), 64'd1);
    check_output("fl_still_drain", 64'(bus.drain_busy), 64'd1);
    check_output("fl_drain_grant2", 64'(bus.grant_valid), 64'd0);
    step();
    apply_stimulus(16'hFFFF, 16'hFFFF, 64'hF1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("fl_exit_drain", 64'(bus.drain_busy), 64'd0);
    check_output("fl_exit_cnt", 64'(bus.inflight_cnt), 64'd0);
    check_output("fl_first_grant", 64'(bus.grant_valid), 64'd1);
    step();
    check_output("fl_first_data", bus.issue_data, 64'hF1);

    // Freeze blocks grants but the register drains and fu_done counts
    apply_stimulus(16'hFFFF, 16'hFFFF, 64'h99, 1'b1, 1'b1, 1'b0, 1'b1);
    check_output("frz_no_grant", 64'(bus.grant_valid), 64'd0);
    step();
    check_output("frz_drained", 64'(bus.issue_valid), 64'd0);
    check_output("frz_cnt", 64'(bus.inflight_cnt), 64'd0);

    // Underflow: fu_done with nothing outstanding
    apply_stimulus(16'h0000, 16'hFFFF, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    apply_stimulus(16'h0000, 16'hFFFF, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("uf_cnt", 64'(bus.inflight_cnt), 64'd0);
    check_output("uf_flag", 64'(bus.done_underflow), 64'd1);
    step();
    check_output("uf_sticky", 64'(bus.done_underflow), 64'd1);

    // Reset mid-operation with two outstanding and a stalled op
    apply_stimulus(16'h0001, 16'hFFFF, 64'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    apply_stimulus(16'h0001, 16'hFFFF, 64'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    apply_stimulus(16'hFFFF, 16'hFFFF, 64'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("mr_pre_cnt", 64'(bus.inflight_cnt), 64'd2);
    check_output("mr_pre_data", bus.issue_data, 64'h22);
    RESET = 1'b1;
    #1;
    check_output("mr_valid", 64'(bus.issue_valid), 64'd0);
    check_output("mr_data", bus.issue_data, 64'd0);
    check_output("mr_cnt", 64'(bus.inflight_cnt), 64'd0);
    check_output("mr_underflow", 64'(bus.done_underflow), 64'd0);
    check_output("mr_grant", 64'(bus.grant_valid), 64'd0);
    RESET = 1'b0;
    apply_stimulus(16'h0100, 16'hFFFF, 64'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("mr_run_drain", 64'(bus.drain_busy), 64'd0);
    check_output("mr_run_grant", 64'(bus.grant_valid), 64'd1);
    check_output("mr_run_idx", 64'(bus.grant_idx), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
